// File: rtl/cond_code_unit.sv
// Condition-code unit: registers an ALU beat behind a valid/ready handshake, maintains the
// {OF, ZF, SF} condition-code register and evaluates cmovXX/jXX conditions against it.
module cond_code_unit #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:WIDTH-1] alu_result,
    input  logic             OF,
    input  logic             ZF,
    input  logic             SF,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic             cc_inhibit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:WIDTH-1] out_result,
    output logic             out_cnd,
    output logic             out_ins_err,
    output logic             cc_of,
    output logic             cc_zf,
    output logic             cc_sf
);

    localparam logic [3:0] ICODE_CMOV = 4'd2;
    localparam logic [3:0] ICODE_OPQ  = 4'd6;
    localparam logic [3:0] ICODE_JXX  = 4'd7;

    logic             valid_q, valid_d;
    logic [0:WIDTH-1] result_q, result_d;
    logic             cnd_q, cnd_d;
    logic             err_q, err_d;
    logic             cc_of_q, cc_of_d;
    logic             cc_zf_q, cc_zf_d;
    logic             cc_sf_q, cc_sf_d;

    logic accept;
    logic is_cond_op;
    logic lt;
    logic cond;
    logic bad_fun;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Conditions use the CC contents before this beat's own update.
    always_comb begin
        lt         = cc_sf_q ^ cc_of_q;
        is_cond_op = (icode == ICODE_CMOV) || (icode == ICODE_JXX);
        cond       = 1'b0;
        bad_fun    = 1'b0;
        case (ifun)
            4'd0:    cond = 1'b1;
            4'd1:    cond = lt || cc_zf_q;
            4'd2:    cond = lt;
            4'd3:    cond = cc_zf_q;
            4'd4:    cond = !cc_zf_q;
            4'd5:    cond = !lt;
            4'd6:    cond = !lt && !cc_zf_q;
            default: bad_fun = 1'b1;
        endcase
        if (!is_cond_op) begin
            cond    = 1'b0;
            bad_fun = 1'b0;
        end
    end

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        cnd_d    = cnd_q;
        err_d    = err_q;
        cc_of_d  = cc_of_q;
        cc_zf_d  = cc_zf_q;
        cc_sf_d  = cc_sf_q;
        if (accept) begin
            valid_d  = 1'b1;
            result_d = alu_result;
            cnd_d    = cond;
            err_d    = bad_fun;
            if (icode == ICODE_OPQ && !cc_inhibit) begin
                cc_of_d = OF;
                cc_zf_d = ZF;
                cc_sf_d = SF;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            cnd_q    <= 1'b0;
            err_q    <= 1'b0;
            cc_of_q  <= 1'b0;
            cc_zf_q  <= 1'b1;
            cc_sf_q  <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            cnd_q    <= cnd_d;
            err_q    <= err_d;
            cc_of_q  <= cc_of_d;
            cc_zf_q  <= cc_zf_d;
            cc_sf_q  <= cc_sf_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_result  = result_q;
    assign out_cnd     = cnd_q;
    assign out_ins_err = err_q;
    assign cc_of       = cc_of_q;
    assign cc_zf       = cc_zf_q;
    assign cc_sf       = cc_sf_q;

endmodule

// File: tb/tb_cond_code_unit.sv
// Self-checking bench for cond_code_unit: table-driven beats with a scoreboard queue, plus
// hand-written backpressure and reset-during-stall sequences.
module tb_cond_code_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [0:63] alu_result;
    logic        OF, ZF, SF;
    logic [3:0]  icode, ifun;
    logic        cc_inhibit;
    logic        out_valid;
    logic        out_ready;
    logic [0:63] out_result;
    logic        out_cnd, out_ins_err;
    logic        cc_of, cc_zf, cc_sf;

    cond_code_unit #(.WIDTH(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_result (alu_result),
        .OF         (OF),
        .ZF         (ZF),
        .SF         (SF),
        .icode      (icode),
        .ifun       (ifun),
        .cc_inhibit (cc_inhibit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_cnd    (out_cnd),
        .out_ins_err(out_ins_err),
        .cc_of      (cc_of),
        .cc_zf      (cc_zf),
        .cc_sf      (cc_sf)
    );

    always #5 clk = ~clk;

    // cc is {of, zf, sf} expected after the beat is accepted
    typedef struct {
        logic [3:0] icode;
        logic [3:0] ifun;
        logic       of_f, zf_f, sf_f, inh;
        logic       cnd, err;
        logic [2:0] cc;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic        cnd, err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic [3:0] ic, input logic [3:0] fn, input logic o,
                                input logic z, input logic s, input logic inh, input logic c,
                                input logic e, input logic [2:0] cc);
        vec_t v;
        v.icode = ic; v.ifun = fn; v.of_f = o; v.zf_f = z; v.sf_f = s; v.inh = inh;
        v.cnd = c; v.err = e; v.cc = cc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Enters and leaves at posedge+1; in_valid stays high so beats can go back to back.
    task automatic drive(input vec_t v, input logic [63:0] res);
        exp_t e;
        int   n = 0;
        icode = v.icode; ifun = v.ifun; OF = v.of_f; ZF = v.zf_f; SF = v.sf_f;
        cc_inhibit = v.inh; alu_result = res; in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (in_ready) begin
                e.res = res; e.cnd = v.cnd; e.err = v.err;
                sb.push_back(e);
                @(posedge clk); #1;
                chk("cc_after_beat", {61'd0, cc_of, cc_zf, cc_sf}, {61'd0, v.cc});
                break;
            end
            n++;
            if (n > 20) begin
                n_checks++; n_fail++;
                $display("FAIL accept_timeout: in_ready got 0 expected 1");
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    // Output monitor: a beat is delivered on the edge following a negedge with valid && ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_beat: got result %h expected none", out_result);
                end else begin
                    e = sb.pop_front();
                    chk("out_result", out_result, e.res);
                    chk("out_cnd", {63'd0, out_cnd}, {63'd0, e.cnd});
                    chk("out_ins_err", {63'd0, out_ins_err}, {63'd0, e.err});
                end
            end
        end
    end

    vec_t        tbl[20];
    logic [63:0] res;
    logic [63:0] last_res;
    vec_t        va, vb;

    initial begin
        // icode ifun of zf sf inh | cnd err cc{of,zf,sf}
        tbl[0]  = mk(4'd7, 4'd3,  0, 0, 0, 0, 1, 0, 3'b010);  // je after reset
        tbl[1]  = mk(4'd6, 4'd0,  0, 0, 1, 0, 0, 0, 3'b001);  // OPq sets SF
        tbl[2]  = mk(4'd7, 4'd2,  0, 0, 0, 0, 1, 0, 3'b001);  // jl, no bubble
        tbl[3]  = mk(4'd7, 4'd5,  0, 0, 0, 0, 0, 0, 3'b001);  // jge
        tbl[4]  = mk(4'd6, 4'd0,  0, 1, 0, 0, 0, 0, 3'b010);
        tbl[5]  = mk(4'd6, 4'd0,  0, 0, 1, 1, 0, 0, 3'b010);  // inhibited OPq
        tbl[6]  = mk(4'd2, 4'd4,  0, 0, 0, 0, 0, 0, 3'b010);  // cmovne
        tbl[7]  = mk(4'd7, 4'd9,  1, 0, 1, 0, 0, 1, 3'b010);  // bad ifun
        tbl[8]  = mk(4'd2, 4'd0,  0, 0, 0, 0, 1, 0, 3'b010);  // rrmovq
        tbl[9]  = mk(4'd6, 4'd1,  1, 0, 0, 0, 0, 0, 3'b100);
        tbl[10] = mk(4'd7, 4'd1,  0, 0, 0, 0, 1, 0, 3'b100);  // jle via OF
        tbl[11] = mk(4'd7, 4'd6,  0, 0, 0, 0, 0, 0, 3'b100);  // jg
        tbl[12] = mk(4'd6, 4'd2,  1, 0, 1, 0, 0, 0, 3'b101);
        tbl[13] = mk(4'd7, 4'd6,  0, 0, 0, 0, 1, 0, 3'b101);  // jg, SF==OF
        tbl[14] = mk(4'd2, 4'd15, 0, 0, 0, 0, 0, 1, 3'b101);
        tbl[15] = mk(4'd0, 4'd3,  0, 1, 0, 0, 0, 0, 3'b101);  // other icode
        tbl[16] = mk(4'd7, 4'd4,  0, 0, 0, 0, 1, 0, 3'b101);  // jne
        tbl[17] = mk(4'd7, 4'd7,  0, 0, 0, 0, 0, 1, 3'b101);
        tbl[18] = mk(4'd6, 4'd9,  0, 1, 1, 0, 0, 0, 3'b011);  // OPq ignores ifun error
        tbl[19] = mk(4'd7, 4'd1,  0, 0, 0, 0, 1, 0, 3'b011);  // jle

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; alu_result = '0;
        OF = 1'b0; ZF = 1'b0; SF = 1'b0; icode = 4'd0; ifun = 4'd0; cc_inhibit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_out_cnd", {63'd0, out_cnd}, 64'd0);
        chk("rst_out_ins_err", {63'd0, out_ins_err}, 64'd0);
        chk("rst_cc", {61'd0, cc_of, cc_zf, cc_sf}, 64'b010);
        rst_n = 1'b1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            res = {$urandom(), $urandom()};
            if (i == 3) res = 64'h8000_0000_0000_0001;
            last_res = res;
            drive(tbl[i], res);
        end
        in_valid = 1'b0;

        // Idle cycles with noisy inputs must not disturb CC or the output register.
        icode = 4'd6; OF = 1'b1; ZF = 1'b0; SF = 1'b0; cc_inhibit = 1'b0; alu_result = '1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_cc", {61'd0, cc_of, cc_zf, cc_sf}, 64'b011);
        chk("idle_out_result", out_result, last_res);
        chk("idle_out_valid", {63'd0, out_valid}, 64'd0);

        // Backpressure: one beat stalls three cycles while the next waits upstream.
        out_ready = 1'b0;
        va = mk(4'd2, 4'd0, 0, 0, 0, 0, 1, 0, 3'b011);
        vb = mk(4'd7, 4'd1, 0, 0, 0, 0, 1, 0, 3'b011);
        drive(va, 64'h00FF00FF00FF00FF);
        icode = vb.icode; ifun = vb.ifun; alu_result = 64'h1234_5678_9ABC_DEF0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_out_result", out_result, 64'h00FF00FF00FF00FF);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drive(vb, 64'h1234_5678_9ABC_DEF0);
        chk("replace_out_valid", {63'd0, out_valid}, 64'd1);
        chk("replace_out_result", out_result, 64'h1234_5678_9ABC_DEF0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("drain_scoreboard_empty", 64'(sb.size()), 64'd0);

        // Reset while a beat is stalled; a pending OPq must not reach the CC register.
        out_ready = 1'b0;
        drive(mk(4'd6, 4'd0, 0, 0, 1, 0, 0, 0, 3'b001), 64'hCAFE_F00D_0000_0001);
        icode = 4'd6; OF = 1'b1; ZF = 1'b0; SF = 1'b1; in_valid = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("stall_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("stall_rst_cc", {61'd0, cc_of, cc_zf, cc_sf}, 64'b010);
        @(posedge clk); #1;
        chk("rst_override_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_override_cc", {61'd0, cc_of, cc_zf, cc_sf}, 64'b010);
        chk("rst_override_result", out_result, 64'd0);
        sb.delete();
        in_valid = 1'b0;
        rst_n = 1'b1;
        chk("release_in_ready", {63'd0, in_ready}, 64'd1);

        out_ready = 1'b1;
        drive(mk(4'd7, 4'd3, 0, 0, 0, 0, 1, 0, 3'b010), 64'h0000_0000_0000_00A5);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("final_scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
